// File: rtl/spart_echo_driver_if.sv
// SPART control/handshake bundle shared by the echo driver and the SPART.
// The tri-state databus is kept as a plain inout port on the driver so it
// resolves at the board level together with the SPART's own bus driver.
interface spart_echo_driver_if;
    logic       iocs;    // SPART chip select
    logic       iorw;    // 1 = read from SPART, 0 = write to SPART
    logic [1:0] ioaddr;  // 00 buffer, 01 status, 10 divisor lo, 11 divisor hi
    logic       rda;     // SPART receive data available
    logic       tbr;     // SPART transmit buffer ready

    // Driver side: issues bus cycles, observes the SPART status lines.
    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    // SPART side: decodes bus cycles, reports its buffer status.
    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart_echo_driver.sv
// SPART echo driver: programs the baud divisor selected by br_cfg, pulls
// received bytes into a DEPTH-entry FIFO and writes them back out through the
// SPART transmit buffer, optionally swapping the case of ASCII letters.
// One byte moves per rising edge of rda / tbr (armed by a low level).
module spart_echo_driver #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD0    = 4800,
    parameter int unsigned BAUD1    = 9600,
    parameter int unsigned BAUD2    = 19200,
    parameter int unsigned BAUD3    = 38400,
    parameter int unsigned DEPTH    = 8,      // power of 2, >= 2
    parameter int unsigned XFORM    = 0       // 0 raw echo, 1 ASCII case swap
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 br_cfg,
    spart_echo_driver_if.master        bus,
    inout  wire  [7:0]                 databus,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    // Rounded divisor: (CLK + 8B) / 16B - 1, kept to 16 bits.
    function automatic logic [15:0] calc_div(input longint unsigned baud);
        longint unsigned q;
        q = (longint'(CLK_FREQ) + 8 * baud) / (16 * baud) - 1;
        return q[15:0];
    endfunction

    localparam logic [15:0] DIV_TABLE [4] = '{
        calc_div(longint'(BAUD0)),
        calc_div(longint'(BAUD1)),
        calc_div(longint'(BAUD2)),
        calc_div(longint'(BAUD3))
    };

    // Swap case of ASCII letters when enabled; everything else passes through.
    function automatic logic [7:0] tx_xform(input logic [7:0] b);
        logic is_letter;
        is_letter = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
        if ((XFORM != 0) && is_letter) begin
            return b ^ 8'h20;
        end
        return b;
    endfunction

    typedef enum logic [2:0] {
        S_INIT_LO,
        S_INIT_HI,
        S_IDLE,
        S_RX_READ,
        S_TX_WRITE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      br_cfg_curr_q, br_cfg_curr_d;
    logic            rx_armed_q, rx_armed_d;
    logic            tx_armed_q, tx_armed_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      fifo_mem [DEPTH];

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [15:0]     div_live;
    logic [15:0]     div_curr;
    logic            drive_en;
    logic [7:0]      dout;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign div_live = DIV_TABLE[br_cfg];
    assign div_curr = DIV_TABLE[br_cfg_curr_q];

    // Next-state: sequencing, handshake arming and FIFO bookkeeping.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        br_cfg_curr_d = br_cfg_curr_q;
        rx_armed_d    = rx_armed_q;
        tx_armed_d    = tx_armed_q;
        push          = 1'b0;
        pop           = 1'b0;

        case (state_q)
            S_INIT_LO: begin
                br_cfg_curr_d = br_cfg;
                state_d       = S_INIT_HI;
            end
            S_INIT_HI: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (br_cfg != br_cfg_curr_q) begin
                    state_d = S_INIT_LO;
                end else if (bus.rda && rx_armed_q && !full) begin
                    state_d = S_RX_READ;
                end else if (bus.tbr && tx_armed_q && !empty) begin
                    state_d = S_TX_WRITE;
                end
            end
            S_RX_READ: begin
                push       = 1'b1;
                rx_armed_d = 1'b0;
                state_d    = S_IDLE;
            end
            S_TX_WRITE: begin
                pop        = 1'b1;
                tx_armed_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_INIT_LO;
            end
        endcase

        // A low level re-arms; this wins over the clear on the access cycle so
        // that a flag dropping during the access and rising right after is
        // still seen as a fresh edge.
        if (!bus.rda) begin
            rx_armed_d = 1'b1;
        end
        if (!bus.tbr) begin
            tx_armed_d = 1'b1;
        end
    end

    // FIFO pointer/occupancy update; push and pop are mutually exclusive
    // because they come from different states.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= S_INIT_LO;
            br_cfg_curr_q <= 2'b00;
            rx_armed_q    <= 1'b1;
            tx_armed_q    <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            br_cfg_curr_q <= br_cfg_curr_d;
            rx_armed_q    <= rx_armed_d;
            tx_armed_q    <= tx_armed_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage: captures the SPART read data on the read cycle.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by the
        // reset pointers/count, so stale contents are never observed.
        if (push) begin
            fifo_mem[wr_ptr_q] <= databus;
        end
    end

    // Bus-cycle decode from the registered state; reset forces the bus idle.
    always_comb begin
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = ADDR_BUF;
        drive_en   = 1'b0;
        dout       = 8'h00;
        if (!rst) begin
            case (state_q)
                S_INIT_LO: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_DIV_LO;
                    drive_en   = 1'b1;
                    dout       = div_live[7:0];
                end
                S_INIT_HI: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_DIV_HI;
                    drive_en   = 1'b1;
                    dout       = div_curr[15:8];
                end
                S_RX_READ: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b1;
                    bus.ioaddr = ADDR_BUF;
                end
                S_TX_WRITE: begin
                    bus.iocs   = 1'b1;
                    bus.iorw   = 1'b0;
                    bus.ioaddr = ADDR_BUF;
                    drive_en   = 1'b1;
                    dout       = tx_xform(fifo_mem[rd_ptr_q]);
                end
                default: begin
                    bus.iocs = 1'b0;
                end
            endcase
        end
    end

    // Drive the shared bus only on write cycles; released otherwise.
    assign databus    = drive_en ? dout : 8'bz;

    assign fifo_count = count_q;
    assign fifo_full  = full;

endmodule
